// File: rtl/fpu_normalize_round.sv
// -----------------------------------------------------------------------------
// fpu_normalize_round
//   Post-add stage of the single-precision FPU. Takes the raw sign, biased
//   exponent and extended mantissa from the add/sub stage. It normalizes the
//   mantissa: one right shift when the sum carried out, otherwise one left
//   shift per cycle after cancellation. It then rounds to nearest-even and
//   presents a packed IEEE-754 word on a valid/ready output.
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst           synchronous active-high reset
//   in_valid      upstream operand valid
//   in_ready      stage can accept (high only while idle)
//   in_sign       sign of the raw sum
//   in_exp        biased exponent of the larger operand
//   in_mant       {carry, hidden, frac[22:0], guard, sticky}
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accepts the result
//   out_result    {sign, exp[7:0], frac[22:0]}
//   out_overflow  result saturated to infinity
//   out_underflow result flushed to zero
// -----------------------------------------------------------------------------
module fpu_normalize_round #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [7:0]           in_exp,
  input  logic [26:0]          in_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state, state_nx;

  // Working operand. The exponent is 10 bits so that the +1 from a carry or
  // a rounding overflow past 255 stays visible to the overflow test.
  logic         sign_r, sign_nx;
  logic [9:0]   exp_r, exp_nx;
  logic [26:0]  mant_r, mant_nx;

  logic [31:0]  result_r, result_nx;
  logic         ovf_r, ovf_nx;
  logic         unf_r, unf_nx;

  // Round-to-nearest-even and pack. Returns {overflow, packed word}.
  // mant[25] is the hidden one, mant[24:2] the fraction, mant[1:0] guard/sticky.
  function automatic logic [32:0] round_pack(
    input logic        sign,
    input logic [9:0]  exp,
    input logic [26:0] mant
  );
    logic        lsb;
    logic        grd;
    logic        stk;
    logic        up;
    logic [23:0] frac_sum;
    logic [9:0]  exp_rnd;
    logic [32:0] res;
    lsb      = mant[2];
    grd      = mant[1];
    stk      = mant[0];
    up       = grd & (stk | lsb);
    frac_sum = {1'b0, mant[24:2]} + {23'd0, up};
    // A carry out of the fraction means it wrapped to zero: bump the exponent.
    exp_rnd  = exp + {9'd0, frac_sum[23]};
    if (exp_rnd >= 10'd255) begin
      res = {1'b1, sign, 8'hFF, 23'h0};
    end else begin
      res = {1'b0, sign, exp_rnd[7:0], frac_sum[22:0]};
    end
    return res;
  endfunction

  // Flush-to-zero keeps the sign of the raw sum.
  function automatic logic [31:0] flush_word(input logic sign);
    return {sign, 31'h0};
  endfunction

  // ---- state and datapath registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_r <= 32'h0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      result_r <= result_nx;
      ovf_r    <= ovf_nx;
      unf_r    <= unf_nx;
    end
  end

  // The working operand is always reloaded on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    sign_r <= sign_nx;
    exp_r  <= exp_nx;
    mant_r <= mant_nx;
  end

  // ---- next-state and datapath update ----
  always_comb begin
    state_nx  = state;
    sign_nx   = sign_r;
    exp_nx    = exp_r;
    mant_nx   = mant_r;
    result_nx = result_r;
    ovf_nx    = ovf_r;
    unf_nx    = unf_r;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nx  = in_sign;
          exp_nx   = {2'b00, in_exp};
          mant_nx  = in_mant;
          ovf_nx   = 1'b0;
          unf_nx   = 1'b0;
          state_nx = NORM;
        end
      end

      NORM: begin
        if (mant_r == 27'd0) begin
          // Exact cancellation always gives +0.
          result_nx = 32'h0;
          state_nx  = DONE;
        end else if (mant_r[26]) begin
          // Carry out: shift right once, folding the dropped bit into sticky.
          mant_nx  = {1'b0, mant_r[26:2], mant_r[1] | mant_r[0]};
          exp_nx   = exp_r + 10'd1;
          state_nx = ROUND;
        end else if (exp_r == 10'd0) begin
          result_nx = flush_word(sign_r);
          unf_nx    = 1'b1;
          state_nx  = DONE;
        end else if (mant_r[25]) begin
          state_nx = ROUND;
        end else if (exp_r == 10'd1) begin
          // One more left shift would take the exponent to zero: flush.
          result_nx = flush_word(sign_r);
          unf_nx    = 1'b1;
          state_nx  = DONE;
        end else begin
          mant_nx = {mant_r[25:0], 1'b0};
          exp_nx  = exp_r - 10'd1;
        end
      end

      ROUND: begin
        {ovf_nx, result_nx} = round_pack(sign_r, exp_r, mant_r);
        state_nx = DONE;
      end

      DONE: begin
        // Returning to IDLE here means a new operand is taken at the earliest
        // one cycle after the result handshake.
        if (out_ready) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_result    = result_r;
  assign out_overflow  = ovf_r;
  assign out_underflow = unf_r;

endmodule

// File: tb/tb_fpu_normalize_round.sv
module tb_fpu_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  fpu_normalize_round #(.BUS_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];

  // 0: out_ready low, 1: random, 2: always high
  int ready_mode = 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: value-level normalize/round from the operand alone.
  function automatic void model(input logic s, input logic [7:0] e_in, input logic [26:0] m_in,
                                output logic [31:0] r, output logic o, output logic u,
                                output int lat);
    int          e;
    int          p;
    int          kneed;
    int          rem;
    longint      q;
    logic [26:0] m;
    o = 1'b0;
    u = 1'b0;
    e = int'(e_in);
    m = m_in;
    r = 32'h0;
    lat = 2;
    if (m == 27'd0) return;
    if (m[26]) begin
      m = (m >> 1) | {26'd0, m_in[0]};
      e = e + 1;
      lat = 3;
    end else begin
      p = 0;
      for (int i = 0; i < 26; i++) if (m[i]) p = i;
      kneed = 25 - p;
      if (e == 0 || (e - 1) < kneed) begin
        // Exponent runs out before the hidden bit is reached.
        r = {s, 31'h0};
        u = 1'b1;
        lat = (e == 0) ? 2 : 2 + e - 1;
        return;
      end
      m = m << kneed;
      e = e - kneed;
      lat = 3 + kneed;
    end
    q = longint'(m >> 2);
    rem = int'(m[1:0]);
    if (rem == 3 || (rem == 2 && (q % 2) == 1)) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'h0};
      o = 1'b1;
    end else begin
      r = {s, e[7:0], q[22:0]};
    end
  endfunction

  // Output-side compare: every cycle out_valid is high.
  logic        prev_hold = 1'b0;
  logic [31:0] held_res;
  logic        held_ovf;
  logic        held_unf;
  exp_t        cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
        if (!prev_hold) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            cur = sb[0];
            chk("result", out_result, cur.res);
            chk("overflow", {31'd0, out_overflow}, {31'd0, cur.ovf});
            chk("underflow", {31'd0, out_underflow}, {31'd0, cur.unf});
            chk("latency", cyc - cur.t_acc, cur.lat);
          end
          held_res = out_result;
          held_ovf = out_overflow;
          held_unf = out_underflow;
        end else begin
          chk("hold_result", out_result, held_res);
          chk("hold_flags", {30'd0, out_overflow, out_underflow}, {30'd0, held_ovf, held_unf});
        end
        if (out_ready && sb.size() > 0) void'(sb.pop_front());
      end
      prev_hold = out_valid && !out_ready;
    end
  end

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("timeout_in_ready", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m);
    exp_t x;
    wait_ready();
    model(s, e, m, x.res, x.ovf, x.unf, x.lat);
    x.t_acc = cyc;
    sb.push_back(x);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = $urandom_range(0, 1);
    in_exp   = 8'($urandom);
    in_mant  = 27'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic pin(input string nm, input logic s, input logic [7:0] e, input logic [26:0] m,
                     input logic [31:0] r_req, input logic o_req, input logic u_req, input int l_req);
    logic [31:0] r;
    logic        o;
    logic        u;
    int          l;
    model(s, e, m, r, o, u, l);
    chk({nm, "_res"}, r, r_req);
    chk({nm, "_flags"}, {30'd0, o, u}, {30'd0, o_req, u_req});
    chk({nm, "_lat"}, l, l_req);
  endtask

  logic [7:0]  exp_tab [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd200, 8'd253, 8'd254, 8'd255, 8'd20};
  logic [31:0] tmp;
  logic [26:0] lowmask;
  logic [26:0] rm;
  logic [7:0]  re;
  int          p;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 8'd0;
    in_mant  = 27'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_result", out_result, 32'h0);
    chk("reset_flags", {30'd0, out_overflow, out_underflow}, 32'd0);

    // Pin the model with hand-computed values.
    pin("pin_carry", 1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 3);
    pin("pin_zero", 1'b1, 8'd90, 27'h0, 32'h00000000, 1'b0, 1'b0, 2);
    pin("pin_k2", 1'b0, 8'd127, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 5);
    pin("pin_tie_odd", 1'b0, 8'd127, {2'b01, 23'h000001, 2'b10}, 32'h3F800002, 1'b0, 1'b0, 3);
    pin("pin_tie_wrap", 1'b0, 8'd127, {2'b01, 23'h7FFFFF, 2'b10}, 32'h40000000, 1'b0, 1'b0, 3);
    pin("pin_ovf", 1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 3);
    pin("pin_unf", 1'b0, 8'd1, 27'h0800000, 32'h00000000, 1'b0, 1'b1, 2);
    pin("pin_tie_even", 1'b1, 8'd100, {2'b01, 23'h000002, 2'b10}, 32'hB2000002, 1'b0, 1'b0, 3);

    // Directed operands through the DUT.
    send(1'b0, 8'd127, 27'h4000000);
    send(1'b1, 8'd127, 27'h0);
    send(1'b0, 8'd127, 27'h0800000);
    send(1'b0, 8'd127, {2'b01, 23'h000001, 2'b10});
    send(1'b0, 8'd127, {2'b01, 23'h7FFFFF, 2'b10});
    send(1'b0, 8'd254, 27'h4000000);
    send(1'b0, 8'd1, 27'h0800000);
    send(1'b1, 8'd0, 27'h2000000);
    send(1'b0, 8'd255, 27'h5000003);
    send(1'b1, 8'd60, 27'h0000001);
    drain();

    // Back-pressure: hold out_ready low across the result.
    ready_mode = 0;
    send(1'b1, 8'd130, 27'h0123457);
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    ready_mode = 2;
    drain();

    // Reset in the middle of normalization.
    send(1'b0, 8'd127, 27'h0000008);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_flags", {30'd0, out_overflow, out_underflow}, 32'd0);

    // Randomized operands with random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      p = $urandom_range(0, 27);
      if (p == 27) begin
        rm = 27'd0;
      end else begin
        tmp     = $urandom;
        lowmask = (27'd1 << p) - 27'd1;
        rm      = (27'd1 << p) | (tmp[26:0] & lowmask);
      end
      if ($urandom_range(0, 1) == 1) re = exp_tab[$urandom_range(0, 9)];
      else re = 8'($urandom);
      send(1'($urandom_range(0, 1)), re, rm);
    end
    drain();
    ready_mode = 2;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
